pic_command_sequencer: RTL
==========================

// Module: pic_command_sequencer
// PURPOSE
//  Clocked successor of the PIC bus-side decode. Captures CPU writes (CS#/WR#/A0) and commits them on the WR# rising edge.
//  Runs the ICW1..ICW4 initialisation state machine, then decodes OCW1/2/3 into registered control state.
//  Drives the status read-back mux (IRR/ISR/IMR; optionally the poll word). Sits between the data bus buffer and
//  the priority resolver / in-service logic; owns IMR and all init-time configuration.
// PARAMETERS
//  NUM_IRQ    8      request lines handled, 1..8; IMR/IRR/ISR width; unused read bits return 0
//  IMR_RESET  8'h00  IMR value after reset and after every ICW1 (low NUM_IRQ bits used)
// PORTS
//  clk              in   1        single clock; all state changes on rising edge
//  reset_bar        in   1        synchronous reset, active-low
//  chip_select_bar  in   1        CS#, sampled on clk
//  read_bar         in   1        RD#, sampled on clk
//  write_bar        in   1        WR#, sampled on clk
//  A0               in   1        register select
//  data_in          in   8        CPU write data
//  irr              in   NUM_IRQ  interrupt request register, for read-back
//  isr              in   NUM_IRQ  in-service register, for read-back
//  data_out         out  8        read-back data
//  data_out_en      out  1        drive enable for the external tristate
//  init_done        out  1        init sequence complete (state READY)
//  init_clear       out  1        1-cycle pulse on ICW1 commit; downstream clears ISR/priority
//  ltim / sngl / ic4  out  1 each  ICW1 D3 / D1 / D0
//  vector_base      out  5        ICW2 D7:D3
//  cascade_cfg      out  8        ICW3 byte
//  aeoi / upm       out  1 each   ICW4 D1 / D0
//  imr              out  NUM_IRQ  interrupt mask register (OCW1)
//  ocw2_strobe      out  1        1-cycle pulse per OCW2 commit
//  ocw2_rsl         out  3        OCW2 D7:D5 (R,SL,EOI), valid with strobe
//  ocw2_level       out  3        OCW2 D2:D0, valid with strobe
//  read_isr_sel     out  1        1 = A0=0 read returns ISR, 0 = IRR
//  special_mask     out  1        special mask mode
// BEHAVIOUR
//  Reset (reset_bar=0 at clk edge): state WAIT_ICW1; every output 0 except imr=IMR_RESET; capture cleared.
//  Capture: each cycle with ~write_bar & ~chip_select_bar, latch data_in, A0, wr_cs=1.
//  Commit: write_bar seen low the previous cycle, high now, and wr_cs=1 -> commit captured word this cycle;
//   registered outputs update on the next edge (1-cycle latency after the WR# rising edge is sampled).
//   wr_cs then clears. CS# deasserting together with WR# still commits.
//  Decode of a committed word (A0, D):
//   A0=0 & D4=1 -> ICW1, from ANY state: latch ltim/sngl/ic4; imr<=IMR_RESET; read_isr_sel<=0; special_mask<=0;
//    aeoi<=0; upm<=0; init_clear pulse; state->WAIT_ICW2.
//   WAIT_ICW1: all other words ignored.
//   WAIT_ICW2: A0=1 -> vector_base<=D7:D3; next WAIT_ICW3 if !sngl, else WAIT_ICW4 if ic4, else READY.
//   WAIT_ICW3: A0=1 -> cascade_cfg<=D; next WAIT_ICW4 if ic4 else READY.
//   WAIT_ICW4: A0=1 -> aeoi<=D1, upm<=D0; -> READY.
//   In WAIT_ICW2..4, A0=0 words other than ICW1 are ignored; state unchanged.
//   READY, A0=1 -> OCW1: imr<=D[NUM_IRQ-1:0].
//   READY, A0=0, D4=0, D3=0 -> OCW2: ocw2_strobe=1 for exactly one cycle; rsl/level held until the next OCW2.
//   READY, A0=0, D4=0, D3=1 -> OCW3: D1(RR)=1 -> read_isr_sel<=D0; D6(ESMM)=1 -> special_mask<=D5.
//  init_done = (state==READY); it drops the cycle after an ICW1 commit.
//  Read: data_out_en = ~read_bar & ~chip_select_bar & write_bar. Write wins: simultaneous RD#/WR# gives en=0.
//   Combinational from registers: A0=1 -> imr, A0=0 -> isr or irr per read_isr_sel; upper 8-NUM_IRQ bits 0.
//   data_out = 0 while data_out_en=0. Reads never change state (except poll, below).
//  Reset during capture: capture discarded, no commit.
// CONFIGURATION
//  POLL_CMD_EN defined: OCW3 D2(P)=1 arms poll_pend (overrides RR/RIS for the next read).
//   While poll_pend: A0=0 read returns {I, 4'b0, W[2:0]}; I=|(irr&~imr); W=lowest-index unmasked irr bit.
//   poll_pend clears on the RD# rising edge; this also drives a 1-cycle poll_ack out port that exists only under the macro.
//  POLL_CMD_EN undefined: D2 ignored; no poll_ack port, no poll logic.
// STRUCTURE
//  Package pic_cmd_pkg: state enum (WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY), ICW/OCW bit-position
//   localparams (D4_ICW1, D3_OCW3, RR, RIS, ESMM, SMM, P), poll word layout.
//  Sub-module pic_bus_strobe: capture regs + WR#/RD# rising-edge detect; emits commit pulse, captured A0/data, rd_done.
// TESTING
//  ICW1=8'h13 (sngl, ic4), ICW2=8'h20, ICW4=8'h03 -> vector_base=5'h04, aeoi=1, upm=1, init_done after ICW4 commit.
//  ICW1=8'h11, ICW2=8'h08, ICW3=8'h04, ICW4=8'h01 -> cascade_cfg=8'h04 and state passes through WAIT_ICW3.
//  READY: OCW1=8'hA5 -> imr=8'hA5; read A0=1 -> data_out=8'hA5, data_out_en=1.
//  OCW2=8'h63 -> one ocw2_strobe pulse, rsl=3'b011, level=3'd3; OCW3=8'h0B then A0=0 read returns isr.
//  ICW1 mid-init (after ICW2) and while READY with imr=8'hFF -> init_clear pulse, imr=IMR_RESET, state WAIT_ICW2.
//  reset_bar low while WR# low -> no commit on the WR# rising edge; all outputs at reset values.
//  POLL_CMD_EN: irr=8'h28, imr=8'h08, OCW3=8'h0C -> next read 8'h85, then poll_ack; the following read returns irr.

Source files
------------

// File: rtl/pic_cmd_pkg.sv
// PIC command sequencer shared definitions: init/operate state
// encoding, ICW/OCW bit positions, poll word layout and helpers.
package pic_cmd_pkg;

   typedef enum logic [2:0] {
      WAIT_ICW1 = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } seq_state_t;

   // ICW1 / OCW2 / OCW3 discriminators (A0=0 words)
   localparam int unsigned D4_ICW1 = 4;
   localparam int unsigned D3_OCW3 = 3;

   // ICW1 fields
   localparam int unsigned LTIM = 3;
   localparam int unsigned SNGL = 1;
   localparam int unsigned IC4  = 0;

   // ICW4 fields
   localparam int unsigned AEOI = 1;
   localparam int unsigned UPM  = 0;

   // OCW3 fields
   localparam int unsigned ESMM = 6;
   localparam int unsigned SMM  = 5;
   localparam int unsigned P    = 2;
   localparam int unsigned RR   = 1;
   localparam int unsigned RIS  = 0;

   // Poll word: {I, 4'b0, W[2:0]}
   localparam int unsigned POLL_I = 7;

   function automatic logic [2:0] lowest_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pic_bus_strobe.sv
// Bus-side capture of CPU writes and WR#/RD# rising-edge detection.
// Ports: clk, reset_bar, CS#/RD#/WR#/A0/data_in in; commit, cap_a0, cap_data, rd_done out.
module pic_bus_strobe (
   input  logic       clk,
   input  logic       reset_bar,
   input  logic       chip_select_bar,
   input  logic       read_bar,
   input  logic       write_bar,
   input  logic       a0,
   input  logic [7:0] data_in,
   output logic       commit,
   output logic       cap_a0,
   output logic [7:0] cap_data,
   output logic       rd_done
);

   logic       wr_prev_q, wr_prev_d;
   logic       rd_prev_q, rd_prev_d;
   logic       wr_cs_q,   wr_cs_d;
   logic       rd_cs_q,   rd_cs_d;
   logic       a0_q,      a0_d;
   logic [7:0] data_q,    data_d;

   // WR# high now, low last cycle, with a captured selected write.
   // CS# is not required here so CS#/WR# rising together still commits.
   assign commit   = wr_cs_q & ~wr_prev_q & write_bar;
   assign rd_done  = rd_cs_q & ~rd_prev_q & read_bar;
   assign cap_a0   = a0_q;
   assign cap_data = data_q;

   always_comb begin
      wr_prev_d = write_bar;
      rd_prev_d = read_bar;
      wr_cs_d   = wr_cs_q;
      rd_cs_d   = rd_cs_q;
      a0_d      = a0_q;
      data_d    = data_q;
      if (commit) wr_cs_d = 1'b0;
      if (rd_done) rd_cs_d = 1'b0;
      if (!write_bar && !chip_select_bar) begin
         wr_cs_d = 1'b1;
         a0_d    = a0;
         data_d  = data_in;
      end
      if (!read_bar && !chip_select_bar && write_bar)
         rd_cs_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         wr_prev_q <= 1'b1;
         rd_prev_q <= 1'b1;
         wr_cs_q   <= 1'b0;
         rd_cs_q   <= 1'b0;
         a0_q      <= 1'b0;
         data_q    <= 8'h00;
      end else begin
         wr_prev_q <= wr_prev_d;
         rd_prev_q <= rd_prev_d;
         wr_cs_q   <= wr_cs_d;
         rd_cs_q   <= rd_cs_d;
         a0_q      <= a0_d;
         data_q    <= data_d;
      end
   end

endmodule

// File: rtl/pic_command_sequencer.sv
// PIC ICW1..4 init sequencer, OCW1/2/3 decode and status read-back mux.
// Ports: bus strobes in, irr/isr in; config/imr/ocw2/read-back out. POLL_CMD_EN adds poll_ack.
module pic_command_sequencer
   import pic_cmd_pkg::*;
#(
   parameter int unsigned NUM_IRQ   = 8,
   parameter logic [7:0]  IMR_RESET = 8'h00
) (
   input  logic               clk,
   input  logic               reset_bar,
   input  logic               chip_select_bar,
   input  logic               read_bar,
   input  logic               write_bar,
   input  logic               A0,
   input  logic [7:0]         data_in,
   input  logic [NUM_IRQ-1:0] irr,
   input  logic [NUM_IRQ-1:0] isr,
   output logic [7:0]         data_out,
   output logic               data_out_en,
   output logic               init_done,
   output logic               init_clear,
   output logic               ltim,
   output logic               sngl,
   output logic               ic4,
   output logic [4:0]         vector_base,
   output logic [7:0]         cascade_cfg,
   output logic               aeoi,
   output logic               upm,
   output logic [NUM_IRQ-1:0] imr,
`ifdef POLL_CMD_EN
   output logic               poll_ack,
`endif
   output logic               ocw2_strobe,
   output logic [2:0]         ocw2_rsl,
   output logic [2:0]         ocw2_level,
   output logic               read_isr_sel,
   output logic               special_mask
);

   localparam logic [NUM_IRQ-1:0] IMR_INIT = IMR_RESET[NUM_IRQ-1:0];

   logic       commit, cap_a0;
   logic [7:0] d;

   seq_state_t         state_q, state_d;
   logic               clr_q, clr_d;
   logic               ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
   logic [4:0]         vec_q, vec_d;
   logic [7:0]         cas_q, cas_d;
   logic               aeoi_q, aeoi_d, upm_q, upm_d;
   logic [NUM_IRQ-1:0] imr_q, imr_d;
   logic               stb_q, stb_d;
   logic [2:0]         rsl_q, rsl_d, lvl_q, lvl_d;
   logic               risel_q, risel_d, smm_q, smm_d;
   logic [7:0]         rd_word;

`ifdef POLL_CMD_EN
   logic       rd_done;
   logic       poll_q, poll_d, ack_q, ack_d;
   logic [7:0] pend;
`endif

   pic_bus_strobe u_strobe (
      .clk             (clk),
      .reset_bar       (reset_bar),
      .chip_select_bar (chip_select_bar),
      .read_bar        (read_bar),
      .write_bar       (write_bar),
      .a0              (A0),
      .data_in         (data_in),
      .commit          (commit),
      .cap_a0          (cap_a0),
      .cap_data        (d),
`ifdef POLL_CMD_EN
      .rd_done         (rd_done)
`else
      .rd_done         ()
`endif
   );

   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      ltim_d  = ltim_q;
      sngl_d  = sngl_q;
      ic4_d   = ic4_q;
      vec_d   = vec_q;
      cas_d   = cas_q;
      aeoi_d  = aeoi_q;
      upm_d   = upm_q;
      imr_d   = imr_q;
      stb_d   = 1'b0;
      rsl_d   = rsl_q;
      lvl_d   = lvl_q;
      risel_d = risel_q;
      smm_d   = smm_q;
`ifdef POLL_CMD_EN
      poll_d  = poll_q;
      ack_d   = 1'b0;
      if (rd_done && poll_q) begin
         poll_d = 1'b0;
         ack_d  = 1'b1;
      end
`endif
      if (commit) begin
         if (!cap_a0 && d[D4_ICW1]) begin
            ltim_d  = d[LTIM];
            sngl_d  = d[SNGL];
            ic4_d   = d[IC4];
            imr_d   = IMR_INIT;
            risel_d = 1'b0;
            smm_d   = 1'b0;
            aeoi_d  = 1'b0;
            upm_d   = 1'b0;
            clr_d   = 1'b1;
`ifdef POLL_CMD_EN
            poll_d  = 1'b0;
`endif
            state_d = WAIT_ICW2;
         end else begin
            unique case (state_q)
               WAIT_ICW2: if (cap_a0) begin
                  vec_d = d[7:3];
                  if (!sngl_q)  state_d = WAIT_ICW3;
                  else if (ic4_q) state_d = WAIT_ICW4;
                  else          state_d = READY;
               end
               WAIT_ICW3: if (cap_a0) begin
                  cas_d   = d;
                  state_d = ic4_q ? WAIT_ICW4 : READY;
               end
               WAIT_ICW4: if (cap_a0) begin
                  aeoi_d  = d[AEOI];
                  upm_d   = d[UPM];
                  state_d = READY;
               end
               READY: begin
                  if (cap_a0) begin
                     imr_d = d[NUM_IRQ-1:0];
                  end else if (!d[D3_OCW3]) begin
                     stb_d = 1'b1;
                     rsl_d = d[7:5];
                     lvl_d = d[2:0];
                  end else begin
                     if (d[RR])   risel_d = d[RIS];
                     if (d[ESMM]) smm_d   = d[SMM];
`ifdef POLL_CMD_EN
                     if (d[P])    poll_d  = 1'b1;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         state_q <= WAIT_ICW1;
         clr_q   <= 1'b0;
         ltim_q  <= 1'b0;
         sngl_q  <= 1'b0;
         ic4_q   <= 1'b0;
         vec_q   <= 5'd0;
         cas_q   <= 8'h00;
         aeoi_q  <= 1'b0;
         upm_q   <= 1'b0;
         imr_q   <= IMR_INIT;
         stb_q   <= 1'b0;
         rsl_q   <= 3'd0;
         lvl_q   <= 3'd0;
         risel_q <= 1'b0;
         smm_q   <= 1'b0;
`ifdef POLL_CMD_EN
         poll_q  <= 1'b0;
         ack_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         ltim_q  <= ltim_d;
         sngl_q  <= sngl_d;
         ic4_q   <= ic4_d;
         vec_q   <= vec_d;
         cas_q   <= cas_d;
         aeoi_q  <= aeoi_d;
         upm_q   <= upm_d;
         imr_q   <= imr_d;
         stb_q   <= stb_d;
         rsl_q   <= rsl_d;
         lvl_q   <= lvl_d;
         risel_q <= risel_d;
         smm_q   <= smm_d;
`ifdef POLL_CMD_EN
         poll_q  <= poll_d;
         ack_q   <= ack_d;
`endif
      end
   end

   // Write wins over a simultaneous read.
   assign data_out_en = ~read_bar & ~chip_select_bar & write_bar;

`ifdef POLL_CMD_EN
   always_comb begin
      pend = 8'h00;
      pend[NUM_IRQ-1:0] = irr & ~imr_q;
   end
`endif

   always_comb begin
      rd_word = 8'h00;
      if (A0)           rd_word[NUM_IRQ-1:0] = imr_q;
      else if (risel_q) rd_word[NUM_IRQ-1:0] = isr;
      else              rd_word[NUM_IRQ-1:0] = irr;
`ifdef POLL_CMD_EN
      if (!A0 && poll_q) begin
         rd_word         = 8'h00;
         rd_word[POLL_I] = |pend;
         rd_word[2:0]    = lowest_idx(pend);
      end
`endif
   end

   assign data_out     = data_out_en ? rd_word : 8'h00;
   assign init_done    = (state_q == READY);
   assign init_clear   = clr_q;
   assign ltim         = ltim_q;
   assign sngl         = sngl_q;
   assign ic4          = ic4_q;
   assign vector_base  = vec_q;
   assign cascade_cfg  = cas_q;
   assign aeoi         = aeoi_q;
   assign upm          = upm_q;
   assign imr          = imr_q;
   assign ocw2_strobe  = stb_q;
   assign ocw2_rsl     = rsl_q;
   assign ocw2_level   = lvl_q;
   assign read_isr_sel = risel_q;
   assign special_mask = smm_q;
`ifdef POLL_CMD_EN
   assign poll_ack     = ack_q;
`endif

endmodule
